// File: rtl/tt_response_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tt_response_checker
// Purpose  : Sweeps {A,B,C} through 000..111, samples a 3-in/1-out block and
//            scores it against an expected truth table (pass/done/error mask).
// Revision : 1.0 - initial release
// ============================================================================
module tt_response_checker #(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter logic [7:0]  EXPECTED    = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_d,
  output logic [2:0] abc,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_run    = 2'd1;
  localparam logic [1:0] c_done   = 2'd2;
  localparam logic [7:0] c_reload = 8'(HOLD_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [7:0] fail_q, fail_d;

  logic       w_sample;
  logic       w_mis;
  logic       w_last;
  logic [3:0] w_err_upd;
  logic [7:0] w_fail_upd;

  // An unknown response is scored as a mismatch in simulation.
  assign w_sample   = (state_q == c_run) && (cnt_q == 8'd0);
  assign w_mis      = (dut_d !== EXPECTED[idx_q]);
  assign w_last     = (idx_q == 3'd7);
  assign w_err_upd  = err_q + {3'b000, w_mis};
  assign w_fail_upd = fail_q | ({7'd0, w_mis} << idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_idle;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fail_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      c_idle, c_done: if (start) state_d = c_run;
      c_run:          if (w_sample && w_last) state_d = c_done;
      default:        state_d = c_idle;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    abc_d  = abc_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    fail_d = fail_q;
    unique case (state_q)
      c_idle, c_done: begin
        // A new sweep wipes the previous verdict on the same edge.
        if (start) begin
          idx_d  = 3'd0;
          abc_d  = 3'd0;
          cnt_d  = c_reload;
          err_d  = 4'd0;
          fail_d = 8'd0;
          done_d = 1'b0;
          pass_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      c_run: begin
        if (!w_sample) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          err_d  = w_err_upd;
          fail_d = w_fail_upd;
          if (!w_last) begin
            idx_d = idx_q + 3'd1;
            abc_d = idx_q + 3'd1;
            cnt_d = c_reload;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (w_err_upd == 4'd0);
          end
        end
      end
      default: ;
    endcase
  end

  assign abc       = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_response_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tt_response_checker
// Purpose  : Self-checking bench; the DUT-under-test is a truth-table lookup
//            and results are predicted from the truth table and cycle count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_response_checker;

  localparam logic [7:0] MAJ = 8'hE8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       start2 = 1'b0, start1 = 1'b0;
  logic [7:0] fn2 = MAJ, fn1 = MAJ;
  logic       dut_d2, dut_d1;
  logic [2:0] abc2, abc1;
  logic       busy2, busy1, done2, done1, pass2, pass1;
  logic [3:0] err2, err1;
  logic [7:0] fail2, fail1;

  logic       sel1 = 1'b0;
  logic [2:0] o_abc;
  logic       o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [7:0] o_fail;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb dut_d2 = fn2[abc2];
  always_comb dut_d1 = fn1[abc1];

  tt_response_checker #(.HOLD_CYCLES(2), .EXPECTED(MAJ)) u_dut_h2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_d(dut_d2),
    .abc(abc2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fail2)
  );

  tt_response_checker #(.HOLD_CYCLES(1), .EXPECTED(MAJ)) u_dut_h1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_d(dut_d1),
    .abc(abc1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  always_comb begin
    o_abc  = sel1 ? abc1  : abc2;
    o_busy = sel1 ? busy1 : busy2;
    o_done = sel1 ? done1 : done2;
    o_pass = sel1 ? pass1 : pass2;
    o_err  = sel1 ? err1  : err2;
    o_fail = sel1 ? fail1 : fail2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel1) start1 = v;
    else      start2 = v;
  endtask

  // Vector i has been scored once (i+1)*h edges have elapsed since start.
  function automatic int exp_err(input logic [7:0] fn, input int j, input int h);
    int n = 0;
    for (int i = 0; i < 8; i++)
      if ((i + 1) * h <= j && fn[i] != MAJ[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] exp_fail(input logic [7:0] fn, input int j, input int h);
    logic [7:0] m = 8'h00;
    for (int i = 0; i < 8; i++)
      if ((i + 1) * h <= j && fn[i] != MAJ[i]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_abc"},  32'(o_abc),  32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_pass"}, 32'(o_pass), 32'd0);
    check({tag, "_err"},  32'(o_err),  32'd0);
    check({tag, "_fail"}, 32'(o_fail), 32'd0);
  endtask

  // j counts edges after the start edge; restart_at/abort_at are in j units.
  task automatic run_sweep(input int h, input logic [7:0] fn, input int restart_at,
                           input int abort_at, input string name);
    int j, e;
    logic done_e;
    sel1 = (h == 1);
    if (sel1) fn1 = fn; else fn2 = fn;
    @(negedge clk);
    set_start(1'b1);
    for (j = 0; j <= 8 * h + 1; j++) begin
      @(negedge clk);
      set_start(j == restart_at);
      if (j == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals($sformatf("%s_async_rst", name));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_start(1'b0);
        return;
      end
      e      = exp_err(fn, j, h);
      done_e = (j >= 8 * h);
      check($sformatf("%s_abc_j%0d", name, j),  32'(o_abc),  32'((j / h > 7) ? 7 : j / h));
      check($sformatf("%s_busy_j%0d", name, j), 32'(o_busy), 32'(j < 8 * h));
      check($sformatf("%s_done_j%0d", name, j), 32'(o_done), 32'(done_e));
      check($sformatf("%s_err_j%0d", name, j),  32'(o_err),  32'(e));
      check($sformatf("%s_fail_j%0d", name, j), 32'(o_fail), 32'(exp_fail(fn, j, h)));
      check($sformatf("%s_pass_j%0d", name, j), 32'(o_pass), 32'(done_e && e == 0));
    end
  endtask

  initial begin
    int h, ra;
    logic [7:0] fn;

    repeat (3) @(negedge clk);
    sel1 = 1'b0; check_reset_vals("reset_h2");
    sel1 = 1'b1; check_reset_vals("reset_h1");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(2, MAJ, -1, -1, "good");
    run_sweep(2, MAJ ^ 8'h21, -1, -1, "faulty");
    run_sweep(1, 8'hFF, -1, -1, "stuck1");
    run_sweep(2, MAJ, 4, -1, "busy_restart");
    run_sweep(2, MAJ ^ 8'h80, -1, -1, "restart_from_done");
    run_sweep(2, MAJ, -1, 7, "abort");
    run_sweep(2, MAJ, -1, -1, "after_abort");

    for (int it = 0; it < 10; it++) begin
      h  = int'($urandom_range(1, 2));
      fn = ($urandom_range(0, 3) == 0) ? MAJ : 8'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8 * h - 2)) : -1;
      run_sweep(h, fn, ra, -1, $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish before 200000ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
